sim_imem: RTL and testbench

- Behavioural simulation memory that sits directly upstream of the core under the top-level harness.
- Serves the core's fetch/load/store requests over a valid/ready request channel and returns in-order responses after a fixed pipeline latency.
- Buffers responses so the core may backpressure.
- Provides a simple credit-limited outstanding-request bound so no response is ever dropped.

---
 rtl/sim_imem.sv | 195 +++++++++++++++++++
 tb/tb_sim_imem.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_imem.sv
// Behavioural simulation memory: fixed-latency, in-order responses through a
// credit-bounded response queue, so the consumer can backpressure without loss.
module sim_imem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_AW    = 10,
    parameter int ID_W      = 4,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [DATA_W-1:0]              req_wdata,
    input  logic [ID_W-1:0]                req_id,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           rsp_we,
    output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding
);

    localparam int OW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int PS    = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int EW    = 1 + ID_W + DATA_W;
    localparam int WORDS = 1 << MEM_AW;

    // Contents survive reset; only the time-0 image is zero.
    logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

    logic              accept;
    logic              pop;
    logic              push;
    logic [MEM_AW-1:0] idx;
    logic [EW-1:0]     acc_entry;
    logic [EW-1:0]     push_entry;
    logic [PS-1:0]     pipe_valid;
    logic [EW-1:0]     pipe_entry [PS];
    logic [EW-1:0]     fifo [RSP_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [OW-1:0]     count;
    logic [OW-1:0]     outstanding_r;
    logic              fifo_full;
    logic              unused_addr_hi;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Credit check uses registered state only; a same-cycle dequeue does not free a slot early.
    assign req_ready      = !reset && (outstanding_r < OW'(RSP_DEPTH));
    assign accept         = req_valid && req_ready;
    assign idx            = req_addr[MEM_AW-1:0];
    assign unused_addr_hi = ^req_addr[ADDR_W-1:MEM_AW];
    assign acc_entry      = {req_we, req_id, (req_we ? req_wdata : mem[idx])};

    // Memory array write at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && req_we) begin
            mem[idx] <= req_wdata;
        end
    end

    // Latency pipeline valid bits, flushed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < PS; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Latency pipeline payload shift.
    always_ff @(posedge clk) begin
        pipe_entry[0] <= acc_entry;
        for (int i = 1; i < PS; i++) begin
            pipe_entry[i] <= pipe_entry[i-1];
        end
    end

    // The FIFO write itself is one cycle, so the pipeline holds LATENCY-1 stages.
    generate
        if (LATENCY == 1) begin : g_lat_direct
            assign push       = accept;
            assign push_entry = acc_entry;
        end else begin : g_lat_pipe
            assign push       = pipe_valid[PS-1];
            assign push_entry = pipe_entry[PS-1];
        end
    endgenerate

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign fifo_full = (count == OW'(RSP_DEPTH));
    assign {rsp_we, rsp_id, rsp_data} = rsp_valid ? fifo[rd_ptr] : {EW{1'b0}};
    assign outstanding = outstanding_r;

    // Response queue storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= push_entry;
        end
    end

    // Response queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    // In-flight credit counter covering pipeline plus queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_r <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding_r <= outstanding_r + OW'(1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    sim_imem_checker #(
        .EW      (EW),
        .LATENCY (LATENCY)
    ) u_checker (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .fifo_full   (fifo_full),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_payload ({rsp_we, rsp_id, rsp_data})
    );

endmodule

// Simulation-only protocol checks for sim_imem.
module sim_imem_checker #(
    parameter int EW      = 37,
    parameter int LATENCY = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          fifo_full,
    input logic          rsp_valid,
    input logic          rsp_ready,
    input logic [EW-1:0] rsp_payload
);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $fatal(1, "sim_imem: LATENCY must be at least 1");
        end
    endgenerate

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full))
        else $error("sim_imem: response FIFO push while full");

    a_payload_hold: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> $stable(rsp_payload))
        else $error("sim_imem: response payload changed under backpressure");

endmodule

// File: tb/tb_sim_imem.sv
// Directed self-checking bench for sim_imem: latency, wrap, backpressure,
// streaming at the credit bound, and reset with requests in flight.
module tb_sim_imem;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_id;
    logic        rsp_we;
    logic [2:0]  outstanding;

    int n_cmp  = 0;
    int n_fail = 0;

    sim_imem dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_id      (req_id),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_we      (rsp_we),
        .outstanding (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] id);
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_id = id;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0b want 0", req_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if ({rsp_data, rsp_id, rsp_we} !== 37'd0) begin n_fail++; $display("FAIL reset_payload: got %h/%h/%b want 0", rsp_data, rsp_id, rsp_we); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'd1);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'd2);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_early_valid: got %0b want 0", rsp_valid); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd1, 1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_rsp1: got v%0b id%0d we%0b %h want v1 id1 we1 deadbeef", rsp_valid, rsp_id, rsp_we, rsp_data); end
        n_cmp++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL wr_outstanding: got %0d want 2", outstanding); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd2, 1'b0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rd_rsp2: got v%0b id%0d we%0b %h want v1 id2 we0 deadbeef", rsp_valid, rsp_id, rsp_we, rsp_data); end
        n_cmp++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL rd_outstanding: got %0d want 1", outstanding); end
        tick();
        n_cmp++; if ({rsp_valid, outstanding} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL wr_drain: got v%0b out%0d want v0 out0", rsp_valid, outstanding); end
    endtask

    task automatic test_wrap();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h405, 32'h1234, 4'd3);
        tick();
        drive(1'b1, 1'b0, 32'h005, 32'h0, 4'd4);
        tick();
        drive(1'b1, 1'b0, 32'h3FF, 32'h0, 4'd5);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd3, 1'b1, 32'h1234}) begin
            n_fail++; $display("FAIL wrap_wr: got v%0b id%0d we%0b %h want v1 id3 we1 1234", rsp_valid, rsp_id, rsp_we, rsp_data); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd4, 1'b0, 32'h1234}) begin
            n_fail++; $display("FAIL wrap_rd: got v%0b id%0d we%0b %h want v1 id4 we0 1234", rsp_valid, rsp_id, rsp_we, rsp_data); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd5, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL unwritten_rd: got v%0b id%0d we%0b %h want v1 id5 we0 0", rsp_valid, rsp_id, rsp_we, rsp_data); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h10, 32'h0, 4'(i));
            n_cmp++; if (req_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL bp_ready_%0d: got %0b want %0b", i, req_ready, (i < 4)); end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if ({req_ready, outstanding} !== {1'b0, 3'd4}) begin
            n_fail++; $display("FAIL bp_full: got ready%0b out%0d want ready0 out4", req_ready, outstanding); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if ({rsp_valid, rsp_id, rsp_we, rsp_data} !== {1'b1, 4'd0, 1'b0, 32'hDEADBEEF}) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v%0b id%0d we%0b %h want v1 id0 we0 deadbeef", c, rsp_valid, rsp_id, rsp_we, rsp_data); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 4'(i), 32'hDEADBEEF}) begin
                n_fail++; $display("FAIL bp_drain_%0d: got v%0b id%0d %h want v1 id%0d deadbeef", i, rsp_valid, rsp_id, rsp_data, i); end
            tick();
        end
        n_cmp++; if ({rsp_valid, req_ready, outstanding} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL bp_after: got v%0b ready%0b out%0d want v0 ready1 out0", rsp_valid, req_ready, outstanding); end
    endtask

    task automatic test_stream();
        int   next_id;
        int   exp_id;
        int   cyc;
        logic acc;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h405, 32'h0, 4'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        tick(); tick();
        rsp_ready = 1'b1;
        next_id = 4; exp_id = 0; cyc = 0;
        while (exp_id < 16 && cyc < 40) begin
            drive((next_id < 16), 1'b0, 32'h405, 32'h0, 4'(next_id));
            if (cyc == 0) begin
                n_cmp++; if ({req_ready, outstanding} !== {1'b0, 3'd4}) begin
                    n_fail++; $display("FAIL stream_no_bypass: got ready%0b out%0d want ready0 out4", req_ready, outstanding); end
            end
            n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 4'(exp_id), 32'h1234}) begin
                n_fail++; $display("FAIL stream_rsp_%0d: got v%0b id%0d %h want v1 id%0d 1234", cyc, rsp_valid, rsp_id, rsp_data, exp_id); end
            n_cmp++; if (outstanding > 3'd4) begin n_fail++; $display("FAIL stream_bound_%0d: got %0d want <=4", cyc, outstanding); end
            acc = req_valid && req_ready;
            if (rsp_valid && rsp_ready) exp_id++;
            tick();
            if (acc) next_id++;
            cyc++;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL stream_cycles: got %0d want 16", cyc); end
        n_cmp++; if ({rsp_valid, outstanding} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL stream_drain: got v%0b out%0d want v0 out0", rsp_valid, outstanding); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h3FF, 32'h0, 4'(7 + i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL mid_pre_out: got %0d want 3", outstanding); end
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset: got %0b want 0", req_ready); end
        tick();
        n_cmp++; if ({rsp_valid, outstanding, rsp_data, rsp_id} !== {1'b0, 3'd0, 32'd0, 4'd0}) begin
            n_fail++; $display("FAIL mid_flush: got v%0b out%0d %h id%0d want v0 out0 0 id0", rsp_valid, outstanding, rsp_data, rsp_id); end
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %0b want 1", req_ready); end
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_%0d: got v%0b id%0d want v0", c, rsp_valid, rsp_id); end
            tick();
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'd10);
        tick();
        drive(1'b1, 1'b0, 32'h405, 32'h0, 4'd11);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 4'd10, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL mid_mem_a: got v%0b id%0d %h want v1 id10 deadbeef", rsp_valid, rsp_id, rsp_data); end
        tick();
        n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 4'd11, 32'h1234}) begin
            n_fail++; $display("FAIL mid_mem_b: got v%0b id%0d %h want v1 id11 1234", rsp_valid, rsp_id, rsp_data); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end: got %0b want 0", rsp_valid); end
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
